// File: rtl/spi_minion_adapter.sv
// Packet-level bridge between an SPI minion push/pull port and on-chip val/rdy streams.
// Inbound payloads queue in an RX FIFO, outbound payloads in a TX FIFO.

module spi_minion_adapter_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [width-1:0] enq_data,
    input  logic             deq,
    output logic [width-1:0] deq_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             do_enq;
    logic             do_deq;

    // Full/empty come from the start-of-cycle count, so a full FIFO refuses
    // an enqueue even when it is being drained in the same cycle.
    assign full     = (count == CW'(depth));
    assign empty    = (count == '0);
    assign do_enq   = enq & ~full;
    assign do_deq   = deq & ~empty;
    assign deq_data = mem[head];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(depth - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= next_ptr(tail);
            if (do_deq) head <= next_ptr(head);
            count <= count + CW'(do_enq) - CW'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[tail] <= enq_data;
    end
endmodule

module spi_minion_adapter #(
    parameter int nbits       = 10,
    parameter int num_entries = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_en,
    input  logic [nbits-1:0] push_msg,
    input  logic             pull_en,
    output logic [nbits-1:0] pull_msg,
    output logic             send_val,
    output logic [nbits-3:0] send_msg,
    input  logic             send_rdy,
    input  logic             recv_val,
    input  logic [nbits-3:0] recv_msg,
    output logic             recv_rdy,
    output logic             overflow
);
    localparam int PW = nbits - 2;

    logic          rx_full;
    logic          rx_empty;
    logic          tx_full;
    logic          tx_empty;
    logic [PW-1:0] tx_head;
    logic          push_valid;
    logic          unused_spc;

    // The master's spc bit carries no meaning inbound.
    assign unused_spc = push_msg[nbits-2];
    assign push_valid = push_en & push_msg[nbits-1];

    spi_minion_adapter_fifo #(.width(PW), .depth(num_entries)) rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (push_valid),
        .enq_data (push_msg[PW-1:0]),
        .deq      (send_rdy),
        .deq_data (send_msg),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    spi_minion_adapter_fifo #(.width(PW), .depth(num_entries)) tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (recv_val),
        .enq_data (recv_msg),
        .deq      (pull_en),
        .deq_data (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign send_val = ~rx_empty;
    assign recv_rdy = ~tx_full;
    assign pull_msg = {~tx_empty, ~rx_full, tx_empty ? {PW{1'b0}} : tx_head};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_valid && rx_full) begin
            overflow <= 1'b1;
        end
    end
endmodule
